// File: rtl/fft_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// fft_stream_ctrl_if
//   Complex sample stream carrying one frame of FFT/IFFT data.
//   Each sample has a signed real part and a signed imaginary part, plus
//   end-of-frame and frame-mode sideband bits.
//
//   Signals:
//     valid  master -> slave   sample present
//     ready  slave  -> master  sample accepted when valid & ready
//     re     master -> slave   real part, signed W bits
//     im     master -> slave   imaginary part, signed W bits
//     last   master -> slave   last sample of the frame
//     mode   master -> slave   0 = FFT, 1 = IFFT
//
//   Parameter:
//     W      sample component width
// -----------------------------------------------------------------------------
interface fft_stream_ctrl_if #(
  parameter int W = 16
);
  logic                valid;
  logic                ready;
  logic signed [W-1:0] re;
  logic signed [W-1:0] im;
  logic                last;
  logic                mode;

  modport master (output valid, re, im, last, mode, input ready);
  modport slave  (input valid, re, im, last, mode, output ready);
endinterface

// File: rtl/fft_stream_ctrl.sv
// -----------------------------------------------------------------------------
// fft_stream_ctrl
//   Frame controller around a parallel N-point FFT core.
//
//   Operation:
//     - Collects up to N serial complex samples from the input stream.
//     - For IFFT frames, swaps re/im on the way into the core.
//     - Launches the core with a one-cycle core_start pulse and then waits
//       for core_done.
//     - For IFFT frames, swaps re/im back and scales the core result by 1/N.
//     - Streams the result out one bin per handshake.
//
//   Ports:
//     clk, reset              clock; synchronous active-high reset
//     s  (slave stream)       input samples (valid/ready/re/im/last/mode)
//     m  (master stream)      output bins  (valid/ready/re/im/last/mode)
//     core_start              one-cycle launch pulse to the core
//     core_in_re/im           flat N*W core operands, sample k at [k*W +: W]
//     core_done               one-cycle pulse, core_out_re/im valid that cycle
//     core_out_re/im          flat N*W core results, same packing
//     err_len                 one-cycle pulse when a frame is short or truncated
//     frame_cnt               number of frames fully drained (wraps)
//
//   Build option:
//     FFT_IFFT_ROUND_EN  defined:   IFFT scaling rounds half up.
//                        undefined: IFFT scaling truncates toward zero.
// -----------------------------------------------------------------------------
module fft_stream_ctrl #(
  parameter int N    = 8,
  parameter int W    = 16,
  parameter int LOGN = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  fft_stream_ctrl_if.slave  s,
  fft_stream_ctrl_if.master m,
  output logic             core_start,
  output logic [N*W-1:0]   core_in_re,
  output logic [N*W-1:0]   core_in_im,
  input  logic             core_done,
  input  logic [N*W-1:0]   core_out_re,
  input  logic [N*W-1:0]   core_out_im,
  output logic             err_len,
  output logic [15:0]      frame_cnt
);

  typedef enum logic [1:0] {S_FILL, S_LAUNCH, S_WAIT, S_DRAIN} state_t;

  localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

  state_t          state, next_state;
  logic [LOGN-1:0] idx;          // next input slot
  logic [LOGN-1:0] bin;          // current output bin
  logic            frame_mode;   // mode of the frame being filled / in the core
  logic            out_mode;     // mode of the frame being drained
  logic [N*W-1:0]  in_re, in_im, out_re, out_im;
  logic            s_ready_q, m_valid_q;
  logic            s_fire, m_fire, fill_end, cur_mode;

  // Divide by N for the IFFT path. A W+1-bit intermediate keeps the bias
  // addition from overflowing; the shifted result always fits in W bits.
  function automatic logic [W-1:0] ifft_scale(input logic [W-1:0] x);
    logic signed [W:0] t;
    // NOTE: function-local temporaries use blocking assignments; only
    // clocked state uses non-blocking.
    t = signed'({x[W-1], x});
`ifdef FFT_IFFT_ROUND_EN
    t = t + (W+1)'(1 << (LOGN - 1));
`else
    if (x[W-1]) t = t + (W+1)'(N - 1);
`endif
    t = t >>> LOGN;
    return t[W-1:0];
  endfunction

  assign s_fire   = s.valid & s_ready_q;
  assign m_fire   = m_valid_q & m.ready;
  assign fill_end = s_fire & (s.last | (idx == LAST_IDX));
  // The mode travels with the first sample; later samples reuse the latch.
  assign cur_mode = (idx == '0) ? s.mode : frame_mode;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FILL;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch forms.
    next_state = state;
    case (state)
      S_FILL:   if (fill_end) next_state = S_LAUNCH;
      S_LAUNCH: next_state = S_WAIT;
      S_WAIT:   if (core_done) next_state = S_DRAIN;
      S_DRAIN:  if (m_fire && bin == LAST_IDX) next_state = S_FILL;
      default:  next_state = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the frame buffers are reset too, so the core operands and the
      // output stream read as zero until the first frame arrives.
      in_re      <= '0;
      in_im      <= '0;
      out_re     <= '0;
      out_im     <= '0;
      idx        <= '0;
      bin        <= '0;
      frame_mode <= 1'b0;
      out_mode   <= 1'b0;
      s_ready_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      core_start <= 1'b0;
      err_len    <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      // Handshake flags follow the state being entered, so they line up
      // with the state register and need no decode after the edge.
      s_ready_q  <= (next_state == S_FILL);
      core_start <= (next_state == S_LAUNCH);
      m_valid_q  <= (next_state == S_DRAIN);
      err_len    <= 1'b0;

      if (s_fire) begin
        if (idx == '0) frame_mode <= s.mode;
        in_re[int'(idx)*W +: W] <= cur_mode ? s.im : s.re;
        in_im[int'(idx)*W +: W] <= cur_mode ? s.re : s.im;
        if (fill_end) begin
          idx <= '0;
          // Early last or missing last at slot N-1 are both length errors.
          err_len <= s.last ^ (idx == LAST_IDX);
          // Slots past a short frame must not carry the previous frame.
          for (int k = 0; k < N; k++) begin
            if (k > int'(idx)) begin
              in_re[k*W +: W] <= '0;
              in_im[k*W +: W] <= '0;
            end
          end
        end else begin
          idx <= idx + LOGN'(1);
        end
      end

      if (state == S_WAIT && core_done) begin
        out_mode <= frame_mode;
        for (int k = 0; k < N; k++) begin
          if (frame_mode) begin
            out_re[k*W +: W] <= ifft_scale(core_out_im[k*W +: W]);
            out_im[k*W +: W] <= ifft_scale(core_out_re[k*W +: W]);
          end else begin
            out_re[k*W +: W] <= core_out_re[k*W +: W];
            out_im[k*W +: W] <= core_out_im[k*W +: W];
          end
        end
      end

      if (m_fire) begin
        if (bin == LAST_IDX) begin
          bin       <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          bin <= bin + LOGN'(1);
        end
      end
    end
  end

  // in_buf is only written in FILL, so the operands hold through WAIT.
  assign core_in_re = in_re;
  assign core_in_im = in_im;

  assign s.ready = s_ready_q;
  assign m.valid = m_valid_q;
  assign m.re    = out_re[int'(bin)*W +: W];
  assign m.im    = out_im[int'(bin)*W +: W];
  assign m.last  = m_valid_q & (bin == LAST_IDX);
  assign m.mode  = out_mode;

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_stream_ctrl
//   Directed bench for fft_stream_ctrl (N=8, W=16) with an identity stub core
//   that answers core_start with core_done a few cycles later.
// -----------------------------------------------------------------------------
module tb_fft_stream_ctrl;
  localparam int N = 8;
  localparam int W = 16;

  logic clk;
  logic reset;
  logic core_start, core_done, err_len;
  logic [N*W-1:0] core_in_re, core_in_im, core_out_re, core_out_im;
  logic [15:0] frame_cnt;

  fft_stream_ctrl_if #(.W(W)) s_if ();
  fft_stream_ctrl_if #(.W(W)) m_if ();

  fft_stream_ctrl #(.N(N), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .s          (s_if),
    .m          (m_if),
    .core_start (core_start),
    .core_in_re (core_in_re),
    .core_in_im (core_in_im),
    .core_done  (core_done),
    .core_out_re(core_out_re),
    .core_out_im(core_out_im),
    .err_len    (err_len),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Identity core: result equals operands, done three edges after start.
  logic [2:0] done_sh = '0;
  always @(posedge clk) done_sh <= {done_sh[1:0], core_start};
  assign core_done   = done_sh[2];
  assign core_out_re = core_in_re;
  assign core_out_im = core_in_im;

  int err_cnt = 0;
  always @(negedge clk) if (err_len === 1'b1) err_cnt <= err_cnt + 1;

  int vectors    = 0;
  int miscompares = 0;
  int exp_frames = 0;

  logic signed [W-1:0] tx_re [N];
  logic signed [W-1:0] tx_im [N];
  logic signed [W-1:0] exp_re [N];
  logic signed [W-1:0] exp_im [N];

  task automatic clear_tx();
    for (int k = 0; k < N; k++) begin tx_re[k] = '0; tx_im[k] = '0; end
  endtask

  // Forward mode: the identity core returns the (zero-padded) input frame.
  task automatic set_exp_fwd(input int n);
    for (int k = 0; k < N; k++) begin
      exp_re[k] = (k < n) ? tx_re[k] : '0;
      exp_im[k] = (k < n) ? tx_im[k] : '0;
    end
  endtask

  // Sends tx_re/tx_im[0..n-1]; later samples carry the opposite mode bit to
  // show that only the first sample's mode counts.
  task automatic send_frame(input int n, input logic set_last, input logic mode);
    int guard;
    logic signed [W-1:0] er, ei;
    logic exp_err;
    for (int k = 0; k < n; k++) begin
      s_if.valid = 1'b1;
      s_if.re    = tx_re[k];
      s_if.im    = tx_im[k];
      s_if.last  = set_last && (k == n - 1);
      s_if.mode  = (k == 0) ? mode : ~mode;
      guard = 0;
      while (s_if.ready !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
      if (s_if.ready !== 1'b1) begin
        vectors++; miscompares++;
        $display("FAIL send_timeout sample=%0d s_ready=%b want 1", k, s_if.ready);
        s_if.valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    exp_err = set_last ? (n != N) : 1'b1;
    vectors++;
    if (core_start !== 1'b1 || err_len !== exp_err) begin
      miscompares++;
      $display("FAIL launch core_start=%b err_len=%b want 1/%b", core_start, err_len, exp_err);
    end
    for (int k = 0; k < N; k++) begin
      er = (k < n) ? (mode ? tx_im[k] : tx_re[k]) : '0;
      ei = (k < n) ? (mode ? tx_re[k] : tx_im[k]) : '0;
      vectors++;
      if (core_in_re[k*W +: W] !== er || core_in_im[k*W +: W] !== ei) begin
        miscompares++;
        $display("FAIL core_in[%0d] got (%0d,%0d) want (%0d,%0d)", k,
                 $signed(core_in_re[k*W +: W]), $signed(core_in_im[k*W +: W]), er, ei);
      end
    end
  endtask

  // Receives N bins against exp_re/exp_im, stalling at stall_bin.
  task automatic drain_frame(input int stall_bin, input int stall_cycles, input logic exp_mode);
    int guard;
    logic signed [W-1:0] hold_re, hold_im;
    logic hold_last;
    for (int b = 0; b < N; b++) begin
      guard = 0;
      while (m_if.valid !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
      vectors++;
      if (m_if.valid !== 1'b1) begin
        miscompares++;
        $display("FAIL drain_timeout bin=%0d m_valid=%b want 1", b, m_if.valid);
        return;
      end
      if (b == stall_bin) begin
        m_if.ready = 1'b0;
        hold_re = m_if.re; hold_im = m_if.im; hold_last = m_if.last;
        repeat (stall_cycles) begin
          @(posedge clk); #1;
          vectors++;
          if (m_if.valid !== 1'b1 || m_if.re !== hold_re || m_if.im !== hold_im ||
              m_if.last !== hold_last) begin
            miscompares++;
            $display("FAIL stall_hold bin=%0d got v=%b (%0d,%0d) l=%b want v=1 (%0d,%0d) l=%b",
                     b, m_if.valid, m_if.re, m_if.im, m_if.last, hold_re, hold_im, hold_last);
          end
        end
      end
      vectors++;
      if (m_if.re !== exp_re[b] || m_if.im !== exp_im[b]) begin
        miscompares++;
        $display("FAIL bin[%0d] got (%0d,%0d) want (%0d,%0d)", b, m_if.re, m_if.im,
                 exp_re[b], exp_im[b]);
      end
      vectors++;
      if (m_if.last !== (b == N - 1) || m_if.mode !== exp_mode || s_if.ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bin_flags[%0d] got last=%b mode=%b s_ready=%b want %b/%b/0", b,
                 m_if.last, m_if.mode, s_if.ready, (b == N - 1), exp_mode);
      end
      m_if.ready = 1'b1;
      @(posedge clk); #1;
    end
    m_if.ready = 1'b0;
    exp_frames++;
    vectors++;
    if (frame_cnt !== 16'(exp_frames) || m_if.valid !== 1'b0 || s_if.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_end got cnt=%0d m_valid=%b s_ready=%b want %0d/0/1",
               frame_cnt, m_if.valid, s_if.ready, exp_frames);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s_if.valid = 1'b0; s_if.re = '0; s_if.im = '0; s_if.last = 1'b0; s_if.mode = 1'b0;
    m_if.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (s_if.ready !== 1'b0 || m_if.valid !== 1'b0 || core_start !== 1'b0 || err_len !== 1'b0 ||
        frame_cnt !== 16'd0 || m_if.re !== '0 || m_if.im !== '0 || m_if.last !== 1'b0 ||
        m_if.mode !== 1'b0 || core_in_re !== '0) begin
      miscompares++;
      $display("FAIL reset_state s_ready=%b m_valid=%b start=%b err=%b cnt=%0d re=%0d im=%0d want all 0",
               s_if.ready, m_if.valid, core_start, err_len, frame_cnt, m_if.re, m_if.im);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (s_if.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release s_ready=%b want 1", s_if.ready);
    end
  endtask

  task automatic test_fft_passthrough();
    clear_tx();
    tx_re[0] = 16'sd100;
    send_frame(N, 1'b1, 1'b0);
    set_exp_fwd(N);
    drain_frame(-1, 0, 1'b0);
    vectors++;
    if (err_cnt !== 0) begin
      miscompares++;
      $display("FAIL passthrough_err err_len pulses=%0d want 0", err_cnt);
    end
  endtask

  task automatic test_ifft_scale();
    clear_tx();
    tx_re[0] = 16'sd8;   tx_im[0] = 16'sd16;
    tx_re[1] = -16'sd24; tx_im[1] = 16'sd40;
    send_frame(N, 1'b1, 1'b1);
    set_exp_fwd(0);
    exp_re[0] = 16'sd1;  exp_im[0] = 16'sd2;
    exp_re[1] = -16'sd3; exp_im[1] = 16'sd5;
    drain_frame(-1, 0, 1'b1);
  endtask

  task automatic test_rounding();
    clear_tx();
    tx_re[0] = -16'sd13; tx_im[0] = 16'sd12;
    send_frame(N, 1'b1, 1'b1);
    set_exp_fwd(0);
`ifdef FFT_IFFT_ROUND_EN
    exp_re[0] = -16'sd2; exp_im[0] = 16'sd2;
`else
    exp_re[0] = -16'sd1; exp_im[0] = 16'sd1;
`endif
    drain_frame(-1, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < N; k++) begin
      tx_re[k] = 16'(10 * (k + 1));
      tx_im[k] = 16'(-10 * (k + 1));
    end
    send_frame(N, 1'b1, 1'b0);
    set_exp_fwd(N);
    drain_frame(2, 3, 1'b0);
  endtask

  task automatic test_short_frame();
    clear_tx();
    for (int k = 0; k < 5; k++) begin
      tx_re[k] = 16'(2 * k + 1);
      tx_im[k] = 16'(2 * k + 2);
    end
    send_frame(5, 1'b1, 1'b0);
    set_exp_fwd(5);
    drain_frame(-1, 0, 1'b0);
  endtask

  task automatic test_truncation();
    for (int k = 0; k < N; k++) begin tx_re[k] = 16'(k + 100); tx_im[k] = 16'(k); end
    send_frame(N, 1'b0, 1'b0);
    set_exp_fwd(N);
    drain_frame(-1, 0, 1'b0);
    clear_tx();
    tx_re[0] = -16'sd5; tx_im[0] = 16'sd7;
    send_frame(1, 1'b1, 1'b0);
    set_exp_fwd(1);
    drain_frame(-1, 0, 1'b0);
    vectors++;
    if (err_cnt !== 3) begin
      miscompares++;
      $display("FAIL err_len_pulses got %0d want 3", err_cnt);
    end
  endtask

  task automatic test_reset_in_wait();
    clear_tx();
    tx_re[3] = 16'sd55;
    send_frame(N, 1'b1, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_frames = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (m_if.valid !== 1'b0 || s_if.ready !== 1'b1 || frame_cnt !== 16'd0) begin
        miscompares++;
        $display("FAIL reset_wait cyc=%0d m_valid=%b s_ready=%b cnt=%0d want 0/1/0",
                 c, m_if.valid, s_if.ready, frame_cnt);
      end
    end
    for (int k = 0; k < N; k++) begin tx_re[k] = 16'(8 * k); tx_im[k] = 16'(-16 * k); end
    send_frame(N, 1'b1, 1'b1);
    for (int k = 0; k < N; k++) begin exp_re[k] = 16'(k); exp_im[k] = 16'(-2 * k); end
    drain_frame(-1, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_fft_passthrough();
    test_ifft_scale();
    test_rounding();
    test_backpressure();
    test_short_frame();
    test_truncation();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
